piezo_tone: RTL and testbench

Single-note square-wave player driving the differential piezo buzzer pair. Sits directly downstream of the tune sequencers (`sponge`, `charge`). The sequencer hands over one note at a time as a half-period and a duration over a valid/ready handshake. This block toggles `piezo`/`piezo_n` for exactly that duration and signals completion, so back-to-back notes play without gaps.

---
 rtl/piezo_pkg.sv | 14 +
 rtl/piezo_tone.sv | 100 ++++++++++
 tb/tb_piezo_tone.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo tone player and the tune sequencers feeding it.
package piezo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int STEP_FAST = 16;
    localparam int STEP_SLOW = 1;
    localparam int DEF_PER_W = 16;
    localparam int DEF_DUR_W = 25;

endpackage

// File: rtl/piezo_tone.sv
// Single-note square-wave player for the differential piezo pair; accepts one
// note (half-period, duration) per handshake and plays it back-to-back with the next.
module piezo_tone
    import piezo_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1,
    parameter int PER_W    = DEF_PER_W,
    parameter int DUR_W    = DEF_DUR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_vld,
    input  logic [PER_W-1:0] half_per,
    input  logic [DUR_W-1:0] dur,
    output logic             rdy,
    output logic             done,
    output logic             piezo,
    output logic             piezo_n
);

    localparam logic [DUR_W-1:0] STEP = FAST_SIM ? DUR_W'(STEP_FAST) : DUR_W'(STEP_SLOW);

    state_t           state_r;
    logic [DUR_W-1:0] dur_cnt_r;
    logic [PER_W-1:0] per_cnt_r;
    logic [PER_W-1:0] half_per_r;
    logic             piezo_r;
    logic             piezo_n_r;

    logic             last_s;
    logic             rdy_s;
    logic             accept_s;
    logic [DUR_W-1:0] dur_load_s;

    // Handshake decode: the final cycle of a note is already able to take the next one.
    always_comb begin
        last_s   = (state_r == PLAY) && (dur_cnt_r <= STEP);
        rdy_s    = (state_r == IDLE) || last_s;
        accept_s = note_vld && rdy_s;
        if (dur == {DUR_W{1'b0}}) begin
            dur_load_s = DUR_W'(1);
        end else begin
            dur_load_s = dur;
        end
    end

    // Note FSM with duration/half-period counters and the buzzer drive flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            dur_cnt_r  <= {DUR_W{1'b0}};
            per_cnt_r  <= {PER_W{1'b0}};
            half_per_r <= {PER_W{1'b0}};
            piezo_r    <= 1'b0;
            piezo_n_r  <= 1'b0;
        end else if (accept_s) begin
            // A rest keeps both legs low so no DC sits across the buzzer.
            state_r    <= PLAY;
            dur_cnt_r  <= dur_load_s;
            per_cnt_r  <= PER_W'(1);
            half_per_r <= half_per;
            piezo_r    <= (half_per != {PER_W{1'b0}});
            piezo_n_r  <= 1'b0;
        end else begin
            case (state_r)
                PLAY: begin
                    if (last_s) begin
                        state_r   <= IDLE;
                        piezo_r   <= 1'b0;
                        piezo_n_r <= 1'b0;
                    end else begin
                        dur_cnt_r <= dur_cnt_r - STEP;
                        if ((half_per_r != {PER_W{1'b0}}) && (per_cnt_r == half_per_r)) begin
                            piezo_r   <= ~piezo_r;
                            piezo_n_r <= piezo_r;
                            per_cnt_r <= PER_W'(1);
                        end else begin
                            per_cnt_r <= per_cnt_r + PER_W'(1);
                        end
                    end
                end
                IDLE: begin
                    piezo_r   <= 1'b0;
                    piezo_n_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    piezo_r   <= 1'b0;
                    piezo_n_r <= 1'b0;
                end
            endcase
        end
    end

    assign rdy     = rdy_s;
    assign done    = last_s;
    assign piezo   = piezo_r;
    assign piezo_n = piezo_n_r;

endmodule

// File: tb/tb_piezo_tone.sv
// Bench for piezo_tone: a slow-step and a fast-step instance checked every cycle
// against a note-level model, plus directed literal expectations per scenario.
module tb_piezo_tone;

    localparam int PW = 16;
    localparam int DW = 25;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    vld;
    logic [PW-1:0] hp_in  [2];
    logic [DW-1:0] dur_in [2];
    logic [1:0]    rdy_o;
    logic [1:0]    done_o;
    logic [1:0]    pz_o;
    logic [1:0]    pzn_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piezo_tone #(.FAST_SIM(1'b0), .PER_W(PW), .DUR_W(DW)) dut0 (
        .clk(clk), .rst_n(rst_n), .note_vld(vld[0]), .half_per(hp_in[0]), .dur(dur_in[0]),
        .rdy(rdy_o[0]), .done(done_o[0]), .piezo(pz_o[0]), .piezo_n(pzn_o[0])
    );

    piezo_tone #(.FAST_SIM(1'b1), .PER_W(PW), .DUR_W(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .note_vld(vld[1]), .half_per(hp_in[1]), .dur(dur_in[1]),
        .rdy(rdy_o[1]), .done(done_o[1]), .piezo(pz_o[1]), .piezo_n(pzn_o[1])
    );

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Note-level model: which note is active, which cycle of it, and its length.
    int m_act [2] = '{0, 0};
    int m_idx [2] = '{0, 0};
    int m_hp  [2] = '{0, 0};
    int m_n   [2] = '{0, 0};

    function automatic int e_done(input int u);
        return (m_act[u] != 0 && m_idx[u] == m_n[u]) ? 1 : 0;
    endfunction

    function automatic int e_rdy(input int u);
        return (m_act[u] == 0 || m_idx[u] == m_n[u]) ? 1 : 0;
    endfunction

    function automatic int e_pz(input int u);
        if (m_act[u] == 0 || m_hp[u] == 0) return 0;
        return (((m_idx[u] - 1) / m_hp[u]) % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int e_pzn(input int u);
        if (m_act[u] == 0 || m_hp[u] == 0) return 0;
        return 1 - e_pz(u);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_act[u] = 0;
            end else if (vld[u] && e_rdy(u) != 0) begin
                int d;
                d = (dur_in[u] == '0) ? 1 : int'(dur_in[u]);
                m_act[u] = 1;
                m_idx[u] = 1;
                m_hp[u]  = int'(hp_in[u]);
                m_n[u]   = (u == 1) ? (d + 15) / 16 : d;
            end else if (m_act[u] != 0 && m_idx[u] == m_n[u]) begin
                m_act[u] = 0;
            end else if (m_act[u] != 0) begin
                m_idx[u]++;
            end
        end
    end

    // Recorder of play cycles (taken from the DUT handshake) for the literal checks.
    int          cyc     [2] = '{0, 0};
    int          busy    [2] = '{0, 0};
    logic [63:0] wave    [2];
    logic [63:0] nwave   [2];
    logic [63:0] dmask   [2];
    int          clr_gen [2] = '{0, 0};
    int          seen_gen[2] = '{0, 0};

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d piezo", u),   int'(pz_o[u]),   e_pz(u));
            check($sformatf("u%0d piezo_n", u), int'(pzn_o[u]),  e_pzn(u));
            check($sformatf("u%0d rdy", u),     int'(rdy_o[u]),  e_rdy(u));
            check($sformatf("u%0d done", u),    int'(done_o[u]), e_done(u));
            if (clr_gen[u] != seen_gen[u]) begin
                seen_gen[u] = clr_gen[u];
                cyc[u]   = 0;
                busy[u]  = 0;
                wave[u]  = '0;
                nwave[u] = '0;
                dmask[u] = '0;
            end
            if (!rdy_o[u] || done_o[u]) begin
                cyc[u]++;
                if (!rdy_o[u]) busy[u]++;
                wave[u]  = {wave[u][62:0], pz_o[u]};
                nwave[u] = {nwave[u][62:0], pzn_o[u]};
                dmask[u] = {dmask[u][62:0], done_o[u]};
            end
        end
    end

    task automatic clr(input int u);
        clr_gen[u]++;
    endtask

    task automatic send(input int u, input int h, input int d);
        bit acc;
        bit ok;
        ok        = 1'b0;
        vld[u]    = 1'b1;
        hp_in[u]  = PW'(h);
        dur_in[u] = DW'(d);
        for (int t = 0; t < 400; t++) begin
            acc = rdy_o[u];
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        vld[u] = 1'b0;
        check($sformatf("u%0d accepted", u), int'(ok), 1);
    endtask

    task automatic wait_idle(input int u);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (rdy_o[u] && !done_o[u]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("u%0d idle reached", u), int'(ok), 1);
    endtask

    task automatic check_quiet(input string nm);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s u%0d piezo", nm, u),   int'(pz_o[u]),   0);
            check($sformatf("%s u%0d piezo_n", nm, u), int'(pzn_o[u]),  0);
            check($sformatf("%s u%0d rdy", nm, u),     int'(rdy_o[u]),  1);
            check($sformatf("%s u%0d done", nm, u),    int'(done_o[u]), 0);
        end
    endtask

    initial begin
        int dn;
        vld       = 2'b00;
        hp_in[0]  = '0;
        hp_in[1]  = '0;
        dur_in[0] = '0;
        dur_in[1] = '0;
        rst_n     = 1'b0;

        repeat (3) begin
            @(posedge clk);
            #1;
            check_quiet("in reset");
        end
        rst_n = 1'b1;
        #1;
        check_quiet("after reset");
        @(posedge clk);
        #1;

        // Tone 4/20 with an extra offer while busy that must be ignored.
        clr(0);
        send(0, 4, 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vld[0] = 1'b1; hp_in[0] = PW'(1); dur_in[0] = DW'(5);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        wait_idle(0);
        check("tone len",    cyc[0], 20);
        check("tone wave",   int'(wave[0][19:0]),  int'(20'b11110000111100001111));
        check("tone wave_n", int'(nwave[0][19:0]), int'(20'b00001111000011110000));
        check("tone done",   int'(dmask[0][19:0]), 1);
        check("tone end piezo", int'(pz_o[0]), 0);
        check("tone end rdy",   int'(rdy_o[0]), 1);

        // Rest.
        clr(0);
        send(0, 0, 10);
        wait_idle(0);
        check("rest len",    cyc[0], 10);
        check("rest wave",   int'(wave[0][9:0] | nwave[0][9:0]), 0);
        check("rest busy",   busy[0], 9);
        check("rest done",   int'(dmask[0][9:0]), 1);

        // Back-to-back notes with no idle gap.
        clr(0);
        send(0, 4, 8);
        send(0, 2, 6);
        wait_idle(0);
        check("b2b len",  cyc[0], 14);
        check("b2b wave", int'(wave[0][13:0]),  int'(14'b11110000110011));
        check("b2b done", int'(dmask[0][13:0]), int'(14'b00000001000001));

        // Fast-step instance.
        clr(1);
        send(1, 3, 160);
        wait_idle(1);
        check("fast160 len",  cyc[1], 10);
        check("fast160 wave", int'(wave[1][9:0]), int'(10'b1110001110));
        check("fast160 done", int'(dmask[1][9:0]), 1);
        clr(1);
        send(1, 5, 0);
        wait_idle(1);
        check("fast0 len",  cyc[1], 1);
        check("fast0 done", int'(dmask[1][0]), 1);
        clr(1);
        send(1, 2, 17);
        wait_idle(1);
        check("fast17 len",  cyc[1], 2);
        check("fast17 wave", int'(wave[1][1:0]), int'(2'b11));

        // Asynchronous reset in cycle 5 of a 4/20 tone.
        clr(0);
        send(0, 4, 20);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("mid piezo_n", int'(pzn_o[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async piezo",   int'(pz_o[0]),  0);
        check("async piezo_n", int'(pzn_o[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            if (done_o[0]) dn++;
            @(posedge clk);
            #1;
        end
        check("post-reset done pulses", dn, 0);
        check("post-reset rdy", int'(rdy_o[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
